// File: rtl/csr_exu.sv
// CSR execution unit: read-modify-write of one CSR per instruction, with
// illegal-access and ecall traps. Optional macro CSR_EXU_SKIP_WRITE_EN.
module csr_exu #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    // Handshakes (in_* and out_*): a transfer occurs on a rising edge where
    // valid and ready are both high; the producer holds valid and payload
    // stable until that edge, and ready never depends on valid.
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      in_funct3,
    input  logic [11:0]     in_csr_addr,
    input  logic [4:0]      in_rs1_idx,
    input  logic [XLEN-1:0] in_rs1_data,
    input  logic [XLEN-1:0] in_pc,
    input  logic            in_ecall,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_rd_data,
    output logic            out_trap,
    output logic [XLEN-1:0] out_redirect_pc,
    output logic [11:0]     csr_raddr,
    input  logic [XLEN-1:0] csr_rdata,
    input  logic [XLEN-1:0] csr_mtvec,
    input  logic            csr_ro,
    input  logic            csr_exception,
    output logic [11:0]     csr_waddr,
    output logic [XLEN-1:0] csr_wdata,
    output logic [XLEN-1:0] csr_wpc,
    output logic [XLEN-1:0] csr_wcause,
    output logic            csr_wtrap,
    output logic            csr_wvalid,
    output logic [1:0]      o_dbg_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t            r_state;
    logic              r_in_ready;
    logic [2:0]        r_funct3;
    logic [11:0]       r_addr;
    logic [4:0]        r_rs1_idx;
    logic [XLEN-1:0]   r_rs1_data;
    logic [XLEN-1:0]   r_pc;
    logic              r_ecall;
    logic [11:0]       r_csr_raddr;
    logic              r_csr_wvalid;
    logic              r_csr_wtrap;
    logic [11:0]       r_csr_waddr;
    logic [XLEN-1:0]   r_csr_wdata;
    logic [XLEN-1:0]   r_csr_wpc;
    logic [XLEN-1:0]   r_csr_wcause;
    logic              r_out_valid;
    logic              r_out_trap;
    logic [XLEN-1:0]   r_out_rd_data;
    logic [XLEN-1:0]   r_out_redirect_pc;

    logic [XLEN-1:0]   w_operand;
    logic [XLEN-1:0]   w_new_val;
    logic              w_write_int;
    logic              w_illegal;
    logic              w_trap;
    logic [XLEN-1:0]   w_cause;

    // The CSR side is sampled live at the end of READ; the decision made
    // there is captured straight into the registered write/response outputs.
    assign w_operand = r_funct3[2] ? {{(XLEN-5){1'b0}}, r_rs1_idx} : r_rs1_data;

    always_comb begin
        w_new_val = '0;
        case (r_funct3[1:0])
            2'b01:   w_new_val = w_operand;
            2'b10:   w_new_val = csr_rdata | w_operand;
            2'b11:   w_new_val = csr_rdata & ~w_operand;
            default: w_new_val = '0;
        endcase
    end

`ifdef CSR_EXU_SKIP_WRITE_EN
    assign w_write_int = !(r_funct3[1] && (r_rs1_idx == 5'd0));
`else
    assign w_write_int = 1'b1;
`endif

    assign w_illegal = !r_ecall && ((r_funct3[1:0] == 2'b00) || csr_exception
                                    || (csr_ro && w_write_int));
    assign w_trap    = r_ecall || w_illegal;
    assign w_cause   = r_ecall ? XLEN'(11) : XLEN'(2);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state           <= IDLE;
            r_in_ready        <= 1'b1;
            r_funct3          <= '0;
            r_addr            <= '0;
            r_rs1_idx         <= '0;
            r_rs1_data        <= '0;
            r_pc              <= '0;
            r_ecall           <= 1'b0;
            r_csr_raddr       <= '0;
            r_csr_wvalid      <= 1'b0;
            r_csr_wtrap       <= 1'b0;
            r_csr_waddr       <= '0;
            r_csr_wdata       <= '0;
            r_csr_wpc         <= '0;
            r_csr_wcause      <= '0;
            r_out_valid       <= 1'b0;
            r_out_trap        <= 1'b0;
            r_out_rd_data     <= '0;
            r_out_redirect_pc <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid && r_in_ready) begin
                        r_funct3    <= in_funct3;
                        r_addr      <= in_csr_addr;
                        r_rs1_idx   <= in_rs1_idx;
                        r_rs1_data  <= in_rs1_data;
                        r_pc        <= in_pc;
                        r_ecall     <= in_ecall;
                        r_csr_raddr <= in_csr_addr;
                        r_in_ready  <= 1'b0;
                        r_state     <= READ;
                    end
                end
                READ: begin
                    r_csr_raddr       <= '0;
                    r_csr_wvalid      <= w_trap || w_write_int;
                    r_csr_wtrap       <= w_trap;
                    r_csr_waddr       <= w_trap ? 12'd0 : r_addr;
                    r_csr_wdata       <= w_trap ? '0 : w_new_val;
                    r_csr_wpc         <= w_trap ? r_pc : '0;
                    r_csr_wcause      <= w_trap ? w_cause : '0;
                    r_out_trap        <= w_trap;
                    r_out_rd_data     <= w_trap ? '0 : csr_rdata;
                    r_out_redirect_pc <= w_trap ? csr_mtvec : '0;
                    r_state           <= WRITE;
                end
                WRITE: begin
                    r_csr_wvalid <= 1'b0;
                    r_csr_wtrap  <= 1'b0;
                    r_csr_waddr  <= '0;
                    r_csr_wdata  <= '0;
                    r_csr_wpc    <= '0;
                    r_csr_wcause <= '0;
                    r_out_valid  <= 1'b1;
                    r_state      <= RESP;
                end
                RESP: begin
                    if (out_ready) begin
                        r_out_valid       <= 1'b0;
                        r_out_trap        <= 1'b0;
                        r_out_rd_data     <= '0;
                        r_out_redirect_pc <= '0;
                        r_in_ready        <= 1'b1;
                        r_state           <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready        = r_in_ready;
    assign out_valid       = r_out_valid;
    assign out_trap        = r_out_trap;
    assign out_rd_data     = r_out_rd_data;
    assign out_redirect_pc = r_out_redirect_pc;
    assign csr_raddr       = r_csr_raddr;
    assign csr_wvalid      = r_csr_wvalid;
    assign csr_wtrap       = r_csr_wtrap;
    assign csr_waddr       = r_csr_waddr;
    assign csr_wdata       = r_csr_wdata;
    assign csr_wpc         = r_csr_wpc;
    assign csr_wcause      = r_csr_wcause;
    assign o_dbg_state     = r_state;

endmodule
